// File: rtl/ram_ctrl_pkg.sv
// Shared types, default widths and bus-slicing helper for the RAM access arbiter.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned DEPTH_DEF  = 128;
    localparam int unsigned MAX_BUS_W  = 256;

    // Returns field idx of width w from a packed bus, zero-extended to 32 bits.
    function automatic logic [31:0] slice_of(input logic [MAX_BUS_W-1:0] bus,
                                             input int unsigned idx,
                                             input int unsigned w);
        logic [MAX_BUS_W-1:0] shifted;
        logic [31:0]          mask;
        shifted = bus >> (idx * w);
        mask    = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
            if (!gnt_any_o && req_i[cand]) begin
                gnt_any_o   = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin controller sharing one single-port RAM between NUM_REQ requesters.
// state | meaning
// IDLE  | arbitrate, accept one command, latch it
// ISSUE | drive RAM enable with the latched command
// RESP  | one-cycle response (read data, write ack or address error)
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      ram_en,
    output logic                      ram_rw,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    logic              rw_q, rw_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_rw;
    logic               sel_legal;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    always_comb begin
        sel_addr  = ADDR_W'(slice_of(MAX_BUS_W'(req_addr), 32'(gnt_idx), ADDR_W));
        sel_wdata = DATA_W'(slice_of(MAX_BUS_W'(req_wdata), 32'(gnt_idx), DATA_W));
        sel_rw    = req_rw[gnt_idx];
        sel_legal = 64'(sel_addr) < 64'(DEPTH);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        rw_d      = rw_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        req_ready = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        ram_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    req_ready = gnt;
                    ptr_d     = gnt_idx;
                    gidx_d    = gnt_idx;
                    rw_d      = sel_rw;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    err_d     = !sel_legal;
                    state_d   = sel_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                ram_en  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[gidx_q] = 1'b1;
                rsp_err           = err_q;
                rsp_rdata         = (rw_q || err_q) ? '0 : ram_rdata;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // State is already IDLE during reset, but the grant is combinational.
        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            gidx_q  <= '0;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            rw_q    <= rw_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign ram_rw    = rw_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter with a transaction-level scoreboard.
module tb_ram_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_rw = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            ram_en;
    logic            ram_rw;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata = '0;

    logic [DW-1:0] mem [0:127] = '{default: 4'h0};

    ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .DEPTH(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_en    (ram_en),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: registered read, holds data when idle.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_rw) mem[ram_addr[6:0]] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr[6:0]];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no event within cycle budget", name);
    endtask

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int          idx;
        logic [3:0]  data;
        bit          err;
        int          due;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        r;
    logic [3:0]  ref_mem [0:127] = '{default: 4'h0};
    int          cyc, m_free, m_ptr, en_cycle, w;
    logic        en_rw;
    logic [7:0]  en_addr, m_addr;
    logic [3:0]  en_wd, m_wd;
    logic        m_rw;
    logic [N-1:0] exp_ready;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cyc      = 0;
            m_free   = 0;
            m_ptr    = N - 1;
            en_cycle = -1;
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_ram_en", 32'(ram_en), 32'd0);
        end else begin
            cyc++;
            chk("ram_en", 32'(ram_en), 32'(cyc == en_cycle));
            if (cyc == en_cycle) begin
                chk("ram_rw", 32'(ram_rw), 32'(en_rw));
                chk("ram_addr", 32'(ram_addr), 32'(en_addr));
                if (en_rw) chk("ram_wdata", 32'(ram_wdata), 32'(en_wd));
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                r = exp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(1) << r.idx);
                chk("rsp_rdata", 32'(rsp_rdata), 32'(r.data));
                chk("rsp_err", 32'(rsp_err), 32'(r.err));
            end else begin
                chk("rsp_quiet", 32'(rsp_valid), 32'd0);
            end
            w = -1;
            if (cyc >= m_free) begin
                for (int k = 1; k <= N; k++) begin
                    if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
            end
            exp_ready = (w >= 0) ? (N'(1) << w) : '0;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            if (w >= 0) begin
                m_ptr  = w;
                m_addr = req_addr[w*AW +: AW];
                m_wd   = req_wdata[w*DW +: DW];
                m_rw   = req_rw[w];
                r.idx  = w;
                if (m_addr < 8'd128) begin
                    en_cycle = cyc + 1;
                    en_rw    = m_rw;
                    en_addr  = m_addr;
                    en_wd    = m_wd;
                    m_free   = cyc + 3;
                    r.due    = cyc + 2;
                    r.err    = 1'b0;
                    r.data   = m_rw ? 4'h0 : ref_mem[m_addr[6:0]];
                    if (m_rw) ref_mem[m_addr[6:0]] = m_wd;
                end else begin
                    m_free = cyc + 2;
                    r.due  = cyc + 1;
                    r.err  = 1'b1;
                    r.data = 4'h0;
                end
                exp_q.push_back(r);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_cmd(input int i, input logic rw, input logic [7:0] a, input logic [3:0] d);
        req_rw[i]             = rw;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_cmd(input int i, input logic rw, input logic [7:0] a, input logic [3:0] d);
        bit got = 1'b0;
        @(posedge clk); #1;
        set_cmd(i, rw, a, d);
        req_valid[i] = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        if (!got) fail_now("accept_timeout");
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, input logic [3:0] d, input bit e, input string nm);
        bit got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin
                got = 1'b1;
                chk({nm, "_data"}, 32'(rsp_rdata), 32'(d));
                chk({nm, "_err"}, 32'(rsp_err), 32'(e));
            end
        end
        if (!got) fail_now({nm, "_rsp_timeout"});
    endtask

    int           order[$];
    logic [N-1:0] acc;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        do_cmd(0, 1'b1, 8'h05, 4'hA);  wait_rsp(0, 4'h0, 1'b0, "wr05");
        do_cmd(0, 1'b0, 8'h05, 4'h0);  wait_rsp(0, 4'hA, 1'b0, "rd05");
        do_cmd(1, 1'b1, 8'h7F, 4'hF);  wait_rsp(1, 4'h0, 1'b0, "wr7f");
        do_cmd(1, 1'b0, 8'h7F, 4'h0);  wait_rsp(1, 4'hF, 1'b0, "rd7f");
        do_cmd(1, 1'b0, 8'h80, 4'h0);  wait_rsp(1, 4'h0, 1'b1, "ill80");
        do_cmd(2, 1'b1, 8'hFF, 4'h3);  wait_rsp(2, 4'h0, 1'b1, "illff");
        do_cmd(0, 1'b0, 8'h7F, 4'h0);  wait_rsp(0, 4'hF, 1'b0, "rd7f_r0");

        // Reset while a read is in ISSUE, with a request pending.
        do_cmd(0, 1'b0, 8'h05, 4'h0);
        req_valid[0] = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        chk("mid_rst_en", 32'(ram_en), 32'd0);
        chk("mid_rst_rw", 32'(ram_rw), 32'd0);
        chk("mid_rst_addr", 32'(ram_addr), 32'd0);
        chk("mid_rst_wdata", 32'(ram_wdata), 32'd0);
        chk("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("mid_rst_err", 32'(rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        set_cmd(0, 1'b0, 8'h10, 4'h0);
        set_cmd(1, 1'b0, 8'h20, 4'h0);
        req_valid = 3'b011;
        rst = 1'b0;

        // Contention: both held valid, expect 0,1,0,1 every 3 cycles.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready != '0) order.push_back(req_ready[1] ? 1 : (req_ready[0] ? 0 : 2));
        end
        @(posedge clk); #1;
        req_valid = '0;
        chk("cont_grants", 32'(order.size()), 32'd4);
        for (int k = 0; k < order.size() && k < 4; k++) chk("cont_order", 32'(order[k]), 32'(k % 2));
        repeat (4) @(posedge clk);

        // Reassert in the RESP cycle.
        do_cmd(0, 1'b1, 8'h33, 4'h6);
        @(posedge clk); #1;
        chk("b2b_resp_cycle", 32'(rsp_valid), 32'd1);
        set_cmd(0, 1'b0, 8'h33, 4'h0);
        req_valid[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp(0, 4'h6, 1'b0, "b2b_read");
        repeat (3) @(posedge clk);

        // Random traffic.
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 7) == 0)
                        set_cmd(i, 1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)), 4'($urandom));
                    else if ($urandom_range(0, 9) == 0)
                        set_cmd(i, 1'($urandom_range(0, 1)), 8'h7F, 4'($urandom));
                    else
                        set_cmd(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 4'($urandom));
                    req_valid[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
